// File: rtl/param_mdu.sv
// param_mdu: EX-stage multiply/divide unit with HI/LO ownership.
//
// Performs mult/multu/div/divu and, when ACC_EN is set, madd/maddu/msub/msubu.
// Each operation keeps busy high for exactly MULT_LAT or DIV_LAT cycles.
// HI/LO are committed on the edge that ends the last busy cycle. flush cancels
// an in-flight operation without touching HI/LO.
//
// Ports:
//   clk_i       system clock, all state on the rising edge
//   reset_i     synchronous, active-high reset
//   start_i     begin the operation selected by mdu_op_i this cycle
//   mdu_op_i    0 none, 1 mult, 2 multu, 3 div, 4 divu,
//               5 madd, 6 maddu, 7 msub, 8 msubu, others reserved
//   src_a_i     rs operand, also the mthi/mtlo data
//   src_b_i     rt operand
//   hi_we_i     mthi: HI <= src_a_i
//   lo_we_i     mtlo: LO <= src_a_i
//   hi_read_i   mfhi select (has priority over lo_read_i)
//   lo_read_i   mflo select
//   flush_i     cancel the in-flight operation
//   busy_o      registered, operation in progress
//   hi_o        HI register
//   lo_o        LO register
//   mdu_res_o   combinational read result
//
// state  | meaning
// S_IDLE | no operation pending, busy_o = 0
// S_RUN  | operation pending, cnt_q counts down to the commit edge
module param_mdu #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int ACC_EN   = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       mdu_op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic             hi_read_i,
    input  logic             lo_read_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] mdu_res_o
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic op_valid;
    logic op_is_div;

    always_comb begin
        op_valid  = 1'b0;
        op_is_div = 1'b0;
        case (mdu_op_i)
            OP_MULT, OP_MULTU:                     op_valid = 1'b1;
            OP_DIV, OP_DIVU: begin
                op_valid  = 1'b1;
                op_is_div = 1'b1;
            end
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_valid = (ACC_EN != 0);
            default:                               op_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic on the captured operands. Only sampled on the commit edge.
    // ------------------------------------------------------------------
    logic                   signed_op;
    logic [2*WIDTH-1:0]     a_ext, b_ext, prod, acc, acc_add, acc_sub;
    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag, uq, ur, quo, rem;
    logic [2*WIDTH-1:0]     result;

    assign signed_op = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                       (op_q == OP_MADD) || (op_q == OP_MSUB);

    // The low 2*WIDTH bits of the product of sign-extended operands equal the
    // signed product, so one unsigned multiplier serves both flavours.
    assign a_ext   = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign b_ext   = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod    = a_ext * b_ext;
    assign acc     = {hi_q, lo_q};
    assign acc_add = acc + prod;
    assign acc_sub = acc - prod;

    // Signed divide through magnitudes. The -2^(W-1) / -1 case falls out
    // naturally: magnitude quotient 2^(W-1) negates back to itself, remainder 0.
    assign a_neg = signed_op & a_q[WIDTH-1];
    assign b_neg = signed_op & b_q[WIDTH-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
    assign uq    = a_mag / b_mag;
    assign ur    = a_mag % b_mag;

    always_comb begin
        quo = (a_neg ^ b_neg) ? -uq : uq;
        rem = a_neg ? -ur : ur;
        if (b_q == '0) begin
            quo = '1;
            rem = a_q;
        end
    end

    always_comb begin
        result = acc;
        case (op_q)
            OP_MULT, OP_MULTU: result = prod;
            OP_DIV, OP_DIVU:   result = {rem, quo};
            OP_MADD, OP_MADDU: result = acc_add;
            OP_MSUB, OP_MSUBU: result = acc_sub;
            default:           result = acc;
        endcase
    end

    // ------------------------------------------------------------------
    // Control: next state and register updates.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (flush_i) begin
            // Drops the pending result and any same-cycle start or mthi/mtlo.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && op_valid) begin
                        state_d = S_RUN;
                        cnt_d   = op_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
                        op_d    = mdu_op_i;
                        a_d     = src_a_i;
                        b_d     = src_b_i;
                    end else if (!start_i) begin
                        if (hi_we_i) hi_d = src_a_i;
                        if (lo_we_i) lo_d = src_a_i;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CW'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        hi_d    = result[2*WIDTH-1:WIDTH];
                        lo_d    = result[WIDTH-1:0];
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o    = (state_q == S_RUN);
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign mdu_res_o = hi_read_i ? hi_q : (lo_read_i ? lo_q : '0);

endmodule
